reset_conditioner: RTL

- Sits between the raw board reset button and the SoC top-level `reset` input. It feeds `SvarogSoC.reset`.
- Synchronises and debounces the active-low button, then stretches every reset to a guaranteed minimum length.
- Gates a heartbeat LED so the LED blinks only while the SoC is out of reset.
- Counts button-initiated resets for debug visibility.

---
 rtl/reset_conditioner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/reset_conditioner.sv
// Purpose: synchronise and debounce the reset button, stretch SoC reset, gate the heartbeat LED, count presses.
// Latency: pin edge to soc_reset change is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles; the HOLD stretch adds HOLD_CYCLES on release.
// Backpressure: none; free-running and level-based. press_count saturates at 255.
module reset_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 16,
    parameter int BLINK_CYCLES    = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rst_n_pin,
    output logic       soc_reset,
    output logic       running,
    output logic       led,
    output logic [7:0] press_count
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1)    ? $clog2(BLINK_CYCLES)    : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_BTN  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    logic                   stable_n;
    logic [DB_W-1:0]        db_cnt;

    state_t                 state;
    state_t                 next_state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HOLD_W-1:0]      hold_cnt_nxt;
    logic                   armed;

    logic                   soc_reset_d;
    logic                   running_d;
    logic                   press_evt;

    logic [BLINK_W-1:0]     blink_cnt;

    // Synchroniser chain for the asynchronous button; idles at the released level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rst_n_pin};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_n <= 1'b1;
            db_cnt   <= '0;
        end else if (sync_n == stable_n) begin
            db_cnt   <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable_n <= sync_n;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

    // FSM state register; armed marks that the first cycle after reset has elapsed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= next_state;
            hold_cnt <= hold_cnt_nxt;
            armed    <= 1'b1;
        end
    end

    // Next-state logic. HOLD does not count on the first cycle after reset, so
    // soc_reset falls HOLD_CYCLES+1 edges after the last edge reset was high.
    always_comb begin
        next_state   = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_HOLD: begin
                if (!stable_n) begin
                    next_state = ST_BTN;
                end else if (!armed) begin
                    next_state = ST_HOLD;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_state = ST_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!stable_n) begin
                    next_state = ST_BTN;
                end
            end
            ST_BTN: begin
                if (stable_n) begin
                    next_state   = ST_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                next_state   = ST_HOLD;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state change.
    always_comb begin
        soc_reset_d = (next_state != ST_RUN);
        running_d   = (next_state == ST_RUN);
        press_evt   = (next_state == ST_BTN) && (state != ST_BTN);
    end

    // Registered reset and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            soc_reset <= 1'b1;
            running   <= 1'b0;
        end else begin
            soc_reset <= soc_reset_d;
            running   <= running_d;
        end
    end

    // Saturating count of accepted button presses.
    always_ff @(posedge clock) begin
        if (reset) begin
            press_count <= 8'd0;
        end else if (press_evt && (press_count != 8'hFF)) begin
            press_count <= press_count + 8'd1;
        end
    end

    // Heartbeat: toggle every BLINK_CYCLES cycles while running, held dark otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt <= '0;
            led       <= 1'b0;
        end else if (state == ST_RUN) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                led       <= ~led;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt <= '0;
            led       <= 1'b0;
        end
    end

endmodule
